// File: rtl/npc_mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and restoring
// divider sharing one datapath, with a single-cycle bypass for divide-by-zero and overflow.
module npc_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        wb_done,
  output logic        wb_wen,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic        r_neg;
  logic        r_special;
  logic [31:0] r_res;
  logic [63:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic        r_wb_done;
  logic        r_wb_wen;
  logic [4:0]  r_wb_waddr;
  logic [31:0] r_wb_wdata;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready && !flush;
  // in_ready is high only in IDLE and the request inputs are captured on that edge.
  logic w_accept;
  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
  assign wb_done     = r_wb_done;
  assign wb_wen      = r_wb_wen;
  assign wb_waddr    = r_wb_waddr;
  assign wb_wdata    = r_wb_wdata;

  // Request decode: which operands are treated as signed and their magnitudes.
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_is_div;
  logic        w_is_rem;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic        w_res_neg;

  assign w_a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                      (in_op == OP_DIV)  || (in_op == OP_REM);
  assign w_b_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
  assign w_a_neg    = w_a_signed && in_rs1[31];
  assign w_b_neg    = w_b_signed && in_rs2[31];
  assign w_a_mag    = w_a_neg ? (~in_rs1 + 32'd1) : in_rs1;
  assign w_b_mag    = w_b_neg ? (~in_rs2 + 32'd1) : in_rs2;
  assign w_is_div   = in_op[2];
  assign w_is_rem   = in_op[2] && in_op[1];
  assign w_div_zero = w_is_div && (in_rs2 == 32'd0);
  assign w_div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                      (in_rs1 == 32'h8000_0000) && (in_rs2 == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (in_op[1] ? in_rs1 : 32'hFFFF_FFFF)
                                    : (in_op[1] ? 32'd0  : 32'h8000_0000);
  // Remainder follows the dividend sign; quotient/product follow the sign mismatch.
  assign w_res_neg  = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);

  // One iteration step for each algorithm.
  logic [63:0] w_mul_sum;
  logic [32:0] w_trial;
  logic [32:0] w_diff;

  assign w_mul_sum = r_acc + r_a;
  assign w_trial   = {r_acc[31:0], r_b[31]};
  assign w_diff    = w_trial - {1'b0, r_a[31:0]};

  // Final sign fix and result selection, evaluated while in DONE.
  logic [63:0] w_prod;
  logic [31:0] w_div_val;
  logic [31:0] w_div_fix;
  logic [31:0] w_result;

  assign w_prod    = r_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_div_val = r_op[1] ? r_acc[31:0] : r_b;
  assign w_div_fix = r_neg ? (~w_div_val + 32'd1) : w_div_val;
  assign w_result  = r_special        ? r_res :
                     r_op[2]          ? w_div_fix :
                     (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_op       <= 3'd0;
      r_rd       <= 5'd0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_res      <= 32'd0;
      r_a        <= 64'd0;
      r_b        <= 32'd0;
      r_acc      <= 64'd0;
      r_wb_done  <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_wb_waddr <= 5'd0;
      r_wb_wdata <= 32'd0;
    end else begin
      r_wb_done  <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_wb_waddr <= 5'd0;
      r_wb_wdata <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= in_op;
            r_rd      <= in_rd;
            r_neg     <= w_res_neg;
            r_special <= w_special;
            r_res     <= w_special_res;
            // Divide keeps the divisor in r_a and shifts the dividend through r_b.
            r_a       <= {32'd0, (w_is_div ? w_b_mag : w_a_mag)};
            r_b       <= w_is_div ? w_a_mag : w_b_mag;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_state   <= w_special ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_acc   <= 64'd0;
          end else begin
            if (r_op[2]) begin
              r_acc <= {32'd0, (w_diff[32] ? w_trial[31:0] : w_diff[31:0])};
              r_b   <= {r_b[30:0], ~w_diff[32]};
            end else begin
              if (r_b[0]) begin
                r_acc <= w_mul_sum;
              end
              r_a <= {r_a[62:0], 1'b0};
              r_b <= {1'b0, r_b[31:1]};
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_wb_done  <= 1'b1;
            r_wb_wen   <= (r_rd != 5'd0);
            r_wb_waddr <= r_rd;
            r_wb_wdata <= w_result;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
